stopwatch_ctrl: RTL and testbench

STOPWATCH_CTRL -- requirements
Module: stopwatch_ctrl

---
 rtl/stopwatch_ctrl_if.sv | 24 ++
 rtl/stopwatch_ctrl.sv | 129 ++++++++++++
 tb/tb_stopwatch_ctrl.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/stopwatch_ctrl_if.sv
// Button inputs and control outputs of the stopwatch controller, bundled for port hookup.
`timescale 1ns/1ps
interface stopwatch_ctrl_if;
   logic       btn_clear;
   logic       btn_stop;
   logic       btn_lap;
   logic       btn_start;
   logic       tick;
   logic       count_en;
   logic       clear;
   logic       lap_capture;
   logic       show_lap;
   logic [1:0] state;

   modport master (
      output btn_clear, btn_stop, btn_lap, btn_start,
      input  tick, count_en, clear, lap_capture, show_lap, state
   );

   modport slave (
      input  btn_clear, btn_stop, btn_lap, btn_start,
      output tick, count_en, clear, lap_capture, show_lap, state
   );
endinterface

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control: button sync/debounce, tick prescaler, IDLE/RUN/PAUSE FSM and lap-hold timer.
`timescale 1ns/1ps
module stopwatch_ctrl #(
   parameter int unsigned DIV      = 1200000,
   parameter int unsigned DEB      = 16,
   parameter int unsigned LAP_HOLD = 20
) (
   input logic             CLK,
   input logic             RST,
   stopwatch_ctrl_if.slave sw
);
   localparam int unsigned CntW = $clog2(DIV);

   typedef enum logic [1:0] {
      StIdle  = 2'b00,
      StRun   = 2'b01,
      StPause = 2'b10
   } state_e;

   // Button vector order: [0] clear, [1] stop, [2] lap, [3] start
   logic [3:0]      raw;
   logic [3:0]      sync1_q, sync2_q;
   logic [3:0]      level_q, level_d;
   logic [3:0]      prev_q, ev_q;
   logic [3:0][7:0] deb_cnt_q, deb_cnt_d;

   logic [CntW-1:0] pre_q, pre_d;
   logic            tick_next;

   state_e          state_q, state_d;
   logic [4:0]      lap_q, lap_d;
   logic            lap_acc;
   logic            ev_clr, ev_stop, ev_start, ev_lap;

   logic            tick_q, count_en_q, clear_q, lap_cap_q, show_q;

   assign raw = {sw.btn_start, sw.btn_lap, sw.btn_stop, sw.btn_clear};

   always_comb begin
      level_d   = level_q;
      deb_cnt_d = deb_cnt_q;
      for (int i = 0; i < 4; i++) begin
         if (sync2_q[i] == level_q[i]) begin
            deb_cnt_d[i] = '0;
         end else if (deb_cnt_q[i] == 8'(DEB - 1)) begin
            level_d[i]   = sync2_q[i];
            deb_cnt_d[i] = '0;
         end else begin
            deb_cnt_d[i] = deb_cnt_q[i] + 8'd1;
         end
      end
   end

   assign tick_next = (pre_q == CntW'(DIV - 1));
   assign pre_d     = tick_next ? '0 : pre_q + CntW'(1);

   // Fixed priority: clear > stop > start > lap
   assign ev_clr   = ev_q[0];
   assign ev_stop  = ev_q[1] & ~ev_q[0];
   assign ev_start = ev_q[3] & ~ev_q[1] & ~ev_q[0];
   assign ev_lap   = ev_q[2] & ~ev_q[3] & ~ev_q[1] & ~ev_q[0];

   always_comb begin
      state_d = state_q;
      lap_acc = 1'b0;
      if (ev_clr) begin
         state_d = StIdle;
      end else if (ev_stop) begin
         if (state_q == StRun) state_d = StPause;
      end else if (ev_start) begin
         if (state_q != StRun) state_d = StRun;
      end else if (ev_lap) begin
         lap_acc = (state_q != StIdle);
      end
   end

   always_comb begin
      lap_d = lap_q;
      if (ev_clr) begin
         lap_d = '0;
      end else if (lap_acc) begin
         lap_d = 5'(LAP_HOLD);
      end else if (tick_q && (lap_q != 5'd0)) begin
         lap_d = lap_q - 5'd1;
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         sync1_q    <= '0;
         sync2_q    <= '0;
         level_q    <= '0;
         prev_q     <= '0;
         ev_q       <= '0;
         deb_cnt_q  <= '0;
         pre_q      <= '0;
         state_q    <= StIdle;
         lap_q      <= '0;
         tick_q     <= 1'b0;
         count_en_q <= 1'b0;
         clear_q    <= 1'b0;
         lap_cap_q  <= 1'b0;
         show_q     <= 1'b0;
      end else begin
         sync1_q    <= raw;
         sync2_q    <= sync1_q;
         level_q    <= level_d;
         deb_cnt_q  <= deb_cnt_d;
         prev_q     <= level_q;
         ev_q       <= level_q & ~prev_q;
         pre_q      <= pre_d;
         state_q    <= state_d;
         lap_q      <= lap_d;
         tick_q     <= tick_next;
         // Pre-transition state gates counting
         count_en_q <= tick_next && (state_q == StRun) && !ev_clr;
         clear_q    <= ev_clr;
         lap_cap_q  <= lap_acc;
         show_q     <= (lap_d != 5'd0);
      end
   end

   assign sw.tick        = tick_q;
   assign sw.count_en    = count_en_q;
   assign sw.clear       = clear_q;
   assign sw.lap_capture = lap_cap_q;
   assign sw.show_lap    = show_q;
   assign sw.state       = state_q;
endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl with DIV=10, DEB=4, LAP_HOLD=3; edges counted from reset release.
`timescale 1ns/1ps
module tb_stopwatch_ctrl;
   logic CLK = 1'b0;
   logic RST;
   int   total = 0;
   int   bad   = 0;

   stopwatch_ctrl_if sw ();

   stopwatch_ctrl #(
      .DIV      (10),
      .DEB      (4),
      .LAP_HOLD (3)
   ) dut (
      .CLK (CLK),
      .RST (RST),
      .sw  (sw)
   );

   always #5 CLK = ~CLK;

   task automatic check(input string tag, input logic [1:0] obs, input logic [1:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge CLK);
      #1;
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_state"}, sw.state, 2'b00);
      check({tag, "_tick"}, {1'b0, sw.tick}, 2'b00);
      check({tag, "_count_en"}, {1'b0, sw.count_en}, 2'b00);
      check({tag, "_clear"}, {1'b0, sw.clear}, 2'b00);
      check({tag, "_lap_capture"}, {1'b0, sw.lap_capture}, 2'b00);
      check({tag, "_show_lap"}, {1'b0, sw.show_lap}, 2'b00);
   endtask

   initial begin
      RST          = 1'b1;
      sw.btn_clear = 1'b0;
      sw.btn_stop  = 1'b0;
      sw.btn_lap   = 1'b0;
      sw.btn_start = 1'b0;
      step(3);
      check_all_zero("reset");
      @(negedge CLK);
      RST = 1'b0;

      // Prescaler restarts from 0: first tick after edge 10
      step(9);
      check("tick_e9", {1'b0, sw.tick}, 2'b00);
      step(1);
      check("tick_e10", {1'b0, sw.tick}, 2'b01);

      // Glitch of 3 cycles is rejected
      sw.btn_start = 1'b1;
      step(3);
      sw.btn_start = 1'b0;
      step(10);
      check("glitch_state", sw.state, 2'b00);

      // Start press: event at edge 7, RUN at edge 8 (abs 30/31)
      sw.btn_start = 1'b1;
      step(7);
      check("start_e7_state", sw.state, 2'b00);
      check("start_e7_tick", {1'b0, sw.tick}, 2'b01);
      check("start_e7_cnt_en", {1'b0, sw.count_en}, 2'b00);
      step(1);
      check("start_e8_state", sw.state, 2'b01);
      sw.btn_start = 1'b0;
      step(8);
      check("e39_cnt_en", {1'b0, sw.count_en}, 2'b00);
      step(1);
      check("e40_tick", {1'b0, sw.tick}, 2'b01);
      check("e40_cnt_en", {1'b0, sw.count_en}, 2'b01);
      step(1);
      check("e41_cnt_en", {1'b0, sw.count_en}, 2'b00);
      step(9);
      check("e50_tick", {1'b0, sw.tick}, 2'b01);
      check("e50_cnt_en", {1'b0, sw.count_en}, 2'b01);

      // Stop and start together: stop wins
      sw.btn_stop  = 1'b1;
      sw.btn_start = 1'b1;
      step(7);
      check("stopstart_e57_state", sw.state, 2'b01);
      step(1);
      check("stopstart_e58_state", sw.state, 2'b10);
      step(2);
      check("pause_e60_tick", {1'b0, sw.tick}, 2'b01);
      check("pause_e60_cnt_en", {1'b0, sw.count_en}, 2'b00);
      sw.btn_stop  = 1'b0;
      sw.btn_start = 1'b0;

      // Resume from PAUSE
      step(10);
      sw.btn_start = 1'b1;
      step(8);
      check("resume_e78_state", sw.state, 2'b01);
      sw.btn_start = 1'b0;
      step(2);
      check("resume_e80_cnt_en", {1'b0, sw.count_en}, 2'b01);

      // Lap: capture at 88, hold through ticks at 90/100/110, drop at 111
      sw.btn_lap = 1'b1;
      step(7);
      check("lap_e87_cap", {1'b0, sw.lap_capture}, 2'b00);
      step(1);
      check("lap_e88_cap", {1'b0, sw.lap_capture}, 2'b01);
      check("lap_e88_show", {1'b0, sw.show_lap}, 2'b01);
      step(1);
      check("lap_e89_cap", {1'b0, sw.lap_capture}, 2'b00);
      sw.btn_lap = 1'b0;
      step(12);
      check("lap_e101_show", {1'b0, sw.show_lap}, 2'b01);
      step(9);
      check("lap_e110_show", {1'b0, sw.show_lap}, 2'b01);
      check("lap_e110_tick", {1'b0, sw.tick}, 2'b01);
      step(1);
      check("lap_e111_show", {1'b0, sw.show_lap}, 2'b00);

      // Second lap, then clear while show_lap is high
      sw.btn_lap = 1'b1;
      step(8);
      check("lap2_e119_cap", {1'b0, sw.lap_capture}, 2'b01);
      sw.btn_lap   = 1'b0;
      sw.btn_clear = 1'b1;
      step(7);
      check("clr_e126_clear", {1'b0, sw.clear}, 2'b00);
      check("clr_e126_show", {1'b0, sw.show_lap}, 2'b01);
      check("clr_e126_state", sw.state, 2'b01);
      step(1);
      check("clr_e127_clear", {1'b0, sw.clear}, 2'b01);
      check("clr_e127_state", sw.state, 2'b00);
      check("clr_e127_show", {1'b0, sw.show_lap}, 2'b00);
      sw.btn_clear = 1'b0;
      step(1);
      check("clr_e128_clear", {1'b0, sw.clear}, 2'b00);

      // Lap in IDLE is discarded
      sw.btn_lap = 1'b1;
      step(8);
      check("idle_lap_cap", {1'b0, sw.lap_capture}, 2'b00);
      check("idle_lap_state", sw.state, 2'b00);
      sw.btn_lap = 1'b0;

      // Clear in IDLE still pulses
      sw.btn_clear = 1'b1;
      step(8);
      check("idle_clr_pulse", {1'b0, sw.clear}, 2'b01);
      sw.btn_clear = 1'b0;
      step(1);
      check("idle_clr_end", {1'b0, sw.clear}, 2'b00);

      // Reset mid-RUN with start held
      step(5);
      sw.btn_start = 1'b1;
      step(8);
      check("rst_pre_state", sw.state, 2'b01);
      step(3);
      RST = 1'b1;
      #1;
      check_all_zero("rst_async");
      repeat (2) @(posedge CLK);
      @(negedge CLK);
      RST = 1'b0;
      // First edge after release samples the button; RUN follows 7 edges later
      step(1);
      check("rel_e1_state", sw.state, 2'b00);
      step(6);
      check("rel_e7_state", sw.state, 2'b00);
      step(1);
      check("rel_e8_state", sw.state, 2'b01);
      step(1);
      check("rel_e9_tick", {1'b0, sw.tick}, 2'b00);
      step(1);
      check("rel_e10_tick", {1'b0, sw.tick}, 2'b01);
      check("rel_e10_cnt_en", {1'b0, sw.count_en}, 2'b01);
      sw.btn_start = 1'b0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
